// File: rtl/l_tree_gen_if.sv
// l_tree_gen bus bundle: control/status, dual-port pk RAM and thash_h links.
// master is the L-tree engine, slave is the surrounding environment.
interface l_tree_gen_if #(
  parameter int WOTS_LEN_MAX = 67,
  parameter int KEY_LEN      = 256,
  parameter int AW           = $clog2(WOTS_LEN_MAX)
);

  logic                   start;
  logic [AW:0]            len;
  logic [255:0]           hash_addr;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic [KEY_LEN-1:0]     leaf_out;

  logic                   pk_wr_en_0;
  logic [AW-1:0]          pk_addr_0;
  logic [KEY_LEN-1:0]     pk_din_0;
  logic [KEY_LEN-1:0]     pk_dout_0;
  logic                   pk_wr_en_1;
  logic [AW-1:0]          pk_addr_1;
  logic [KEY_LEN-1:0]     pk_din_1;
  logic [KEY_LEN-1:0]     pk_dout_1;

  logic                   th_start;
  logic [2*KEY_LEN-1:0]   th_data_in;
  logic [255:0]           th_addr;
  logic                   th_done;
  logic [KEY_LEN-1:0]     th_dout;

  modport master (
    input  start, len, hash_addr,
    input  pk_dout_0, pk_dout_1,
    input  th_done, th_dout,
    output busy, done, err, leaf_out,
    output pk_wr_en_0, pk_addr_0, pk_din_0,
    output pk_wr_en_1, pk_addr_1, pk_din_1,
    output th_start, th_data_in, th_addr
  );

  modport slave (
    output start, len, hash_addr,
    output pk_dout_0, pk_dout_1,
    output th_done, th_dout,
    input  busy, done, err, leaf_out,
    input  pk_wr_en_0, pk_addr_0, pk_din_0,
    input  pk_wr_en_1, pk_addr_1, pk_din_1,
    input  th_start, th_data_in, th_addr
  );

endinterface

// File: rtl/l_tree_gen.sv
// l_tree_gen: runtime-length L-tree engine folding len WOTS pk nodes
// held in a dual-port RAM into one XMSS leaf via an external thash_h.
module l_tree_gen #(
  parameter int WOTS_LEN_MAX = 67,
  parameter int KEY_LEN      = 256,
  parameter int AW           = $clog2(WOTS_LEN_MAX)
) (
  input logic          clk,
  input logic          reset,
  l_tree_gen_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_WAIT,
    S_WR,
    S_MV_RD,
    S_MV_WR,
    S_NEXT,
    S_FIN,
    S_BYP,
    S_ERR
  } state_t;

  localparam logic [AW:0]   LMAX  = (AW+1)'(WOTS_LEN_MAX);
  localparam logic [AW:0]   L_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] I_ONE = AW'(1);
  localparam logic [255:0]  PASS  =
    {{160{1'b1}}, 64'd0, {32{1'b1}}};

  state_t               r_state;
  state_t               w_nxt;

  logic [AW:0]          r_l;
  logic [31:0]          r_h;
  logic [AW-1:0]        r_i;
  logic [255:0]         r_haddr;
  logic [2*KEY_LEN-1:0] r_th_data;
  logic [KEY_LEN-1:0]   r_res;
  logic [KEY_LEN-1:0]   r_leaf;

  logic [AW-1:0]        w_half;
  logic [AW-1:0]        w_lm1;
  logic [AW:0]          w_lnext;
  logic                 w_lodd;
  logic                 w_last;
  logic                 w_bad;
  logic                 w_one;

  assign w_half  = r_l[AW:1];
  assign w_lodd  = r_l[0];
  assign w_lnext = {1'b0, w_half} + {{AW{1'b0}}, w_lodd};
  assign w_last  = (r_i == w_half - I_ONE);
  // l <= 2**AW, so the low AW bits of l-1 are exact
  assign w_lm1   = r_l[AW-1:0] - I_ONE;
  assign w_bad   = (bus.len == '0) || (bus.len > LMAX);
  assign w_one   = (bus.len == L_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          unique case (1'b1)
            w_bad:   w_nxt = S_ERR;
            w_one:   w_nxt = S_BYP;
            default: w_nxt = S_RD;
          endcase
        end
      end
      S_RD:    w_nxt = S_RDW;
      S_RDW:   w_nxt = S_WAIT;
      S_WAIT:  if (bus.th_done) w_nxt = S_WR;
      S_WR: begin
        if (!w_last) begin
          w_nxt = S_RD;
        end else if (w_lodd) begin
          w_nxt = S_MV_RD;
        end else begin
          w_nxt = S_NEXT;
        end
      end
      S_MV_RD: w_nxt = S_MV_WR;
      S_MV_WR: w_nxt = S_NEXT;
      S_NEXT:  w_nxt = (w_lnext == L_ONE) ? S_FIN : S_RD;
      S_FIN:   w_nxt = S_IDLE;
      S_BYP:   w_nxt = S_FIN;
      S_ERR:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy       = (r_state != S_IDLE);
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    bus.th_start   = 1'b0;
    bus.pk_wr_en_0 = 1'b0;
    bus.pk_addr_0  = '0;
    bus.pk_din_0   = '0;
    bus.pk_wr_en_1 = 1'b0;
    bus.pk_addr_1  = '0;
    bus.pk_din_1   = '0;
    unique case (r_state)
      S_RD: begin
        bus.pk_addr_0 = {r_i[AW-2:0], 1'b0};
        bus.pk_addr_1 = {r_i[AW-2:0], 1'b1};
      end
      S_RDW: bus.th_start = 1'b1;
      S_WR: begin
        bus.pk_wr_en_0 = 1'b1;
        bus.pk_addr_0  = r_i;
        bus.pk_din_0   = r_res;
      end
      S_MV_RD: bus.pk_addr_1 = w_lm1;
      S_MV_WR: begin
        bus.pk_wr_en_1 = 1'b1;
        bus.pk_addr_1  = w_half;
        bus.pk_din_1   = bus.pk_dout_1;
      end
      S_FIN: bus.done = 1'b1;
      S_ERR: begin
        bus.done = 1'b1;
        bus.err  = 1'b1;
      end
      default: ;
    endcase
  end

  // RAM data is live during RDW, so th_start and its payload line up
  assign bus.th_data_in = (r_state == S_RDW) ?
    {bus.pk_dout_0, bus.pk_dout_1} : r_th_data;

  assign bus.th_addr = (r_haddr & PASS) |
    {160'd0, r_h, {(32-AW){1'b0}}, r_i, 32'd0};

  assign bus.leaf_out = r_leaf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_l       <= '0;
      r_h       <= '0;
      r_i       <= '0;
      r_haddr   <= '0;
      r_th_data <= '0;
      r_res     <= '0;
      r_leaf    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_haddr <= bus.hash_addr;
            r_l     <= bus.len;
            r_h     <= '0;
            r_i     <= '0;
            r_leaf  <= '0;
          end
        end
        S_RDW: r_th_data <= {bus.pk_dout_0, bus.pk_dout_1};
        S_WAIT: begin
          if (bus.th_done) r_res <= bus.th_dout;
        end
        S_WR: begin
          if (!w_last) r_i <= r_i + I_ONE;
        end
        S_NEXT: begin
          r_l <= w_lnext;
          r_h <= r_h + 32'd1;
          r_i <= '0;
          if (w_lnext == L_ONE) r_leaf <= r_res;
        end
        S_BYP: r_leaf <= bus.pk_dout_0;
        default: ;
      endcase
    end
  end

endmodule
